// File: rtl/pcileech_pcie_tx_arb_pkg.sv
// Shared definitions for the PCIe transmit arbiter.
// This package holds the arbiter state encoding and the default buffer threshold.
package pcileech_pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } tx_arb_state_t;

    localparam int TX_MIN_BUF_AV_DEF = 2;

endpackage

// File: rtl/pcileech_pcie_tx_arb_rr_pick.sv
// Round-robin priority picker: search starts one past the last grant and wraps.
// The last-granted index itself has the lowest priority.
module pcileech_rr_pick #(
    parameter int NSRC = 3
) (
    input  logic [NSRC-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      winner,
    output logic            valid
);

    // Walk from the lowest priority to the highest so the nearest requester wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NSRC; k >= 1; k--) begin
            if (req[(int'(last) + k) % NSRC]) begin
                winner = 2'((int'(last) + k) % NSRC);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_pcie_tx_arb.sv
// Arbitrates several 64-bit TLP requesters onto the PCIe core s_axis_tx port.
// Grants are locked per packet; a link drop mid-packet drains the source silently.
module pcileech_pcie_tx_arb
    import pcileech_pcie_tx_arb_pkg::*;
#(
    parameter int NSRC       = 3,
    parameter int MIN_BUF_AV = TX_MIN_BUF_AV_DEF
) (
    input  logic        clk_pcie,
    input  logic        rst,
    input  logic        user_lnk_up,
    input  logic [5:0]  tx_buf_av,
    input  logic        tx_cfg_req,
    output logic        tx_cfg_gnt,
    input  logic [63:0] src_data  [NSRC],
    input  logic [7:0]  src_keep  [NSRC],
    input  logic        src_last  [NSRC],
    input  logic        src_valid [NSRC],
    output logic        src_ready [NSRC],
    output logic [63:0] tx_data,
    output logic [7:0]  tx_keep,
    output logic        tx_last,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [1:0]  grant_id,
    output logic [15:0] pkt_count
);

    tx_arb_state_t   state;
    logic [NSRC-1:0] req;
    logic [1:0]      pick_id;
    logic            pick_vld;
    logic            start;
    logic            fwd;
    logic            drop;
    logic            sel_valid;
    logic            sel_last;
    logic            accept_last;
    logic            drop_last;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            req[i] = src_valid[i];
        end
    end

    pcileech_rr_pick #(
        .NSRC (NSRC)
    ) u_pick (
        .req    (req),
        .last   (grant_id),
        .winner (pick_id),
        .valid  (pick_vld)
    );

    assign start = user_lnk_up && (tx_buf_av >= 6'(MIN_BUF_AV)) && !tx_cfg_req && pick_vld;

    // A link drop is honoured in the same cycle it is seen so no beat reaches a dead link.
    assign fwd  = (state == STREAM) && user_lnk_up;
    assign drop = (state == FLUSH) || ((state == STREAM) && !user_lnk_up);

    assign sel_valid   = src_valid[grant_id];
    assign sel_last    = src_last[grant_id];
    assign accept_last = fwd && sel_valid && sel_last && tx_ready;
    assign drop_last   = drop && sel_valid && sel_last;

    assign tx_cfg_gnt = (state != STREAM);

    always_comb begin
        tx_data  = '0;
        tx_keep  = '0;
        tx_last  = 1'b0;
        tx_valid = 1'b0;
        if (fwd) begin
            tx_data  = src_data[grant_id];
            tx_keep  = src_keep[grant_id];
            tx_last  = sel_last;
            tx_valid = sel_valid;
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = (grant_id == 2'(i)) && (fwd ? tx_ready : drop);
        end
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= 2'(NSRC - 1);
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        grant_id <= pick_id;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept_last) begin
                        state     <= IDLE;
                        pkt_count <= pkt_count + 16'd1;
                    end else if (drop_last) begin
                        state <= IDLE;
                    end else if (!user_lnk_up) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (drop_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_pcie_tx_arb.sv
// Directed bench for the PCIe transmit arbiter with hand-computed expectations.
module tb_pcileech_pcie_tx_arb;

    localparam int NSRC = 3;

    logic        clk_pcie = 1'b0;
    logic        rst;
    logic        user_lnk_up;
    logic [5:0]  tx_buf_av;
    logic        tx_cfg_req;
    logic        tx_cfg_gnt;
    logic [63:0] src_data  [NSRC];
    logic [7:0]  src_keep  [NSRC];
    logic        src_last  [NSRC];
    logic        src_valid [NSRC];
    logic        src_ready [NSRC];
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_last;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic [15:0] pkt_count;

    int n_assert = 0;
    int n_fail   = 0;

    pcileech_pcie_tx_arb #(
        .NSRC       (NSRC),
        .MIN_BUF_AV (2)
    ) dut (
        .clk_pcie    (clk_pcie),
        .rst         (rst),
        .user_lnk_up (user_lnk_up),
        .tx_buf_av   (tx_buf_av),
        .tx_cfg_req  (tx_cfg_req),
        .tx_cfg_gnt  (tx_cfg_gnt),
        .src_data    (src_data),
        .src_keep    (src_keep),
        .src_last    (src_last),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .tx_data     (tx_data),
        .tx_keep     (tx_keep),
        .tx_last     (tx_last),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .pkt_count   (pkt_count)
    );

    always #5 clk_pcie = ~clk_pcie;

    task automatic tick();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int s, input logic [63:0] d, input logic l, input logic v);
        src_data[s]  = d;
        src_keep[s]  = 8'hFF;
        src_last[s]  = l;
        src_valid[s] = v;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NSRC; i++) put(i, 64'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; user_lnk_up = 1'b0; tx_buf_av = 6'd8; tx_cfg_req = 1'b0; tx_ready = 1'b1;
        clear_src();
        tick(); tick();

        // Reset state
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd2);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("rst_cfg_gnt", 64'(tx_cfg_gnt), 64'd1);
        chk("rst_ready0", 64'(src_ready[0]), 64'd0);

        // 3-beat packet from src0
        rst = 1'b0; user_lnk_up = 1'b1;
        put(0, 64'hA0, 1'b0, 1'b1); #1;
        chk("p3_c1_valid", 64'(tx_valid), 64'd0);
        tick();
        chk("p3_c2_valid", 64'(tx_valid), 64'd1);
        chk("p3_c2_data", tx_data, 64'hA0);
        chk("p3_grant", 64'(grant_id), 64'd0);
        chk("p3_cfg_gnt", 64'(tx_cfg_gnt), 64'd0);
        chk("p3_ready0", 64'(src_ready[0]), 64'd1);
        chk("p3_ready1", 64'(src_ready[1]), 64'd0);
        put(0, 64'hA1, 1'b0, 1'b1);
        tick();
        chk("p3_c3_data", tx_data, 64'hA1);
        put(0, 64'hA2, 1'b1, 1'b1); #1;
        chk("p3_c4_last", 64'(tx_last), 64'd1);
        chk("p3_c4_pkt", 64'(pkt_count), 64'd0);
        tick();
        put(0, 64'd0, 1'b0, 1'b0); #1;
        chk("p3_idle_valid", 64'(tx_valid), 64'd0);
        chk("p3_idle_data", tx_data, 64'd0);
        chk("p3_idle_cfg", 64'(tx_cfg_gnt), 64'd1);
        chk("p3_pkt", 64'(pkt_count), 64'd1);

        // Round-robin with single-beat packets after a fresh reset
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < NSRC; i++) put(i, 64'h100 + 64'(i), 1'b1, 1'b1);
        #1;
        for (int p = 0; p < 6; p++) begin
            chk("rr_idle_valid", 64'(tx_valid), 64'd0);
            tick();
            chk("rr_grant", 64'(grant_id), 64'(p % 3));
            chk("rr_data", tx_data, 64'h100 + 64'(p % 3));
            tick();
        end
        chk("rr_pkt6", 64'(pkt_count), 64'd6);
        clear_src(); tick();

        // Two-beat packet from src2 with tx_ready toggling 1,0,1,0
        put(2, 64'hB0, 1'b0, 1'b1);
        tick();
        chk("tr_grant", 64'(grant_id), 64'd2);
        chk("tr_b0", tx_data, 64'hB0);
        chk("tr_rdy_a", 64'(src_ready[2]), 64'd1);
        tick();
        put(2, 64'hB1, 1'b1, 1'b1); tx_ready = 1'b0; #1;
        chk("tr_rdy_b", 64'(src_ready[2]), 64'd0);
        chk("tr_b1_hold", tx_data, 64'hB1);
        chk("tr_other_rdy", 64'(src_ready[0]), 64'd0);
        tick();
        tx_ready = 1'b1; #1;
        chk("tr_b1_again", tx_data, 64'hB1);
        chk("tr_rdy_c", 64'(src_ready[2]), 64'd1);
        chk("tr_pkt_before", 64'(pkt_count), 64'd6);
        tick();
        put(2, 64'd0, 1'b0, 1'b0); tx_ready = 1'b0; #1;
        chk("tr_idle", 64'(tx_valid), 64'd0);
        chk("tr_pkt", 64'(pkt_count), 64'd7);
        tx_ready = 1'b1;

        // Core config request blocks new grants
        tx_cfg_req = 1'b1; put(1, 64'hC0, 1'b1, 1'b1);
        tick(); tick();
        chk("cfg_hold_valid", 64'(tx_valid), 64'd0);
        chk("cfg_hold_gnt", 64'(tx_cfg_gnt), 64'd1);
        chk("cfg_hold_grant", 64'(grant_id), 64'd2);
        tx_cfg_req = 1'b0;
        tick();
        chk("cfg_grant", 64'(grant_id), 64'd1);
        chk("cfg_data", tx_data, 64'hC0);
        chk("cfg_gnt_low", 64'(tx_cfg_gnt), 64'd0);
        tick();
        put(1, 64'd0, 1'b0, 1'b0); #1;
        chk("cfg_pkt", 64'(pkt_count), 64'd8);

        // Link drop after first beat of a 4-beat packet
        put(0, 64'hE0, 1'b0, 1'b1);
        tick();
        chk("ld_e0", tx_data, 64'hE0);
        tick();
        user_lnk_up = 1'b0; put(0, 64'hE1, 1'b0, 1'b1); #1;
        chk("ld_e1_valid", 64'(tx_valid), 64'd0);
        chk("ld_e1_ready", 64'(src_ready[0]), 64'd1);
        tick();
        put(0, 64'hE2, 1'b0, 1'b1); #1;
        chk("ld_e2_valid", 64'(tx_valid), 64'd0);
        chk("ld_e2_ready", 64'(src_ready[0]), 64'd1);
        chk("ld_flush_cfg", 64'(tx_cfg_gnt), 64'd1);
        tick();
        put(0, 64'hE3, 1'b1, 1'b1); #1;
        chk("ld_e3_ready", 64'(src_ready[0]), 64'd1);
        tick();
        put(0, 64'd0, 1'b0, 1'b0); #1;
        chk("ld_idle_ready", 64'(src_ready[0]), 64'd0);
        chk("ld_pkt", 64'(pkt_count), 64'd8);
        user_lnk_up = 1'b1;

        // Buffer availability threshold
        tx_buf_av = 6'd1; put(2, 64'hF0, 1'b1, 1'b1);
        tick(); tick();
        chk("buf_hold_valid", 64'(tx_valid), 64'd0);
        chk("buf_hold_grant", 64'(grant_id), 64'd0);
        tx_buf_av = 6'd2;
        tick();
        chk("buf_grant", 64'(grant_id), 64'd2);
        chk("buf_data", tx_data, 64'hF0);
        tick();
        put(2, 64'd0, 1'b0, 1'b0); #1;
        chk("buf_pkt", 64'(pkt_count), 64'd9);

        // Reset mid-packet abandons without flush
        put(1, 64'hD0, 1'b0, 1'b1);
        tick();
        chk("mr_stream", 64'(tx_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("mr_valid", 64'(tx_valid), 64'd0);
        chk("mr_ready", 64'(src_ready[1]), 64'd0);
        chk("mr_grant", 64'(grant_id), 64'd2);
        chk("mr_pkt", 64'(pkt_count), 64'd0);
        chk("mr_cfg", 64'(tx_cfg_gnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
